cpram_pingpong: RTL

Double-buffered, width-converting packet RAM. It is the parametrised successor to the single-bank 64-to-16 converter. A producer writes wide words (RATIO narrow words per beat) into one bank while a consumer reads narrow words from the other bank. Banks are handed over explicitly by commit and release, so a fill and a drain overlap without pointer clobbering.

---
 rtl/cpram_pingpong.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cpram_pingpong.sv
// Double-buffered packet RAM: wide beats fill one bank while narrow words drain the other.
// Banks change hands only on commit (producer side) and release (consumer side).
module cpram_pingpong #(
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned RATIO      = 4,
  parameter int unsigned DEPTH      = 512,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       wr,
  input  logic                       wr_last,
  input  logic [OUT_WIDTH*RATIO-1:0] data,
  output logic                       wr_ready,
  input  logic                       rd,
  input  logic                       rd_release,
  output logic                       rd_avail,
  output logic [$clog2(DEPTH):0]     rd_count,
  output logic [OUT_WIDTH-1:0]       q,
  output logic                       q_valid,
  output logic                       err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned ROWS = DEPTH / RATIO;
  localparam int unsigned RW   = $clog2(2 * ROWS);
  localparam int unsigned LW   = (RATIO > 1) ? $clog2(RATIO) : 1;

  // One lane per slice so a whole beat lands in a single cycle; row = {bank, ptr} / RATIO.
  logic [OUT_WIDTH-1:0] mem [RATIO][2*ROWS];

  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [1:0]           bank_valid_q, bank_valid_d;
  logic [1:0][CW-1:0]   bank_len_q, bank_len_d;
  logic [CW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OUT_WIDTH-1:0] q_q, q_d;
  logic                 q_valid_q, q_valid_d;
  logic                 err_q, err_d;

  logic [CW-1:0]        wr_next;
  logic [CW-1:0]        cur_len;
  logic                 wr_fire, commit, rd_fire, rel_fire;
  logic [RW-1:0]        wr_row, rd_row;
  logic [LW-1:0]        rd_lane;
  logic [OUT_WIDTH-1:0] wr_word [RATIO];

  assign wr_ready = ~bank_valid_q[wr_bank_q];
  assign rd_avail = bank_valid_q[rd_bank_q];
  assign cur_len  = bank_len_q[rd_bank_q];
  assign rd_count = rd_avail ? cur_len : '0;
  assign q        = q_q;
  assign q_valid  = q_valid_q;
  assign err      = err_q;

  assign wr_next  = wr_ptr_q + CW'(RATIO);
  assign wr_fire  = wr & wr_ready & ~clear;
  assign commit   = wr_fire & (wr_last | (wr_next == CW'(DEPTH)));
  assign rd_fire  = rd & rd_avail & (rd_ptr_q < cur_len);
  assign rel_fire = rd_release & rd_avail;

  assign wr_row   = RW'({wr_bank_q, wr_ptr_q[AW-1:0]} / RATIO);
  assign rd_row   = RW'({rd_bank_q, rd_ptr_q[AW-1:0]} / RATIO);
  assign rd_lane  = LW'(rd_ptr_q % RATIO);

  // wr_ptr is always a multiple of RATIO, so slice k always lands in lane k.
  always_comb begin
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (BIG_ENDIAN) begin
        wr_word[k] = data[(RATIO-1-k)*OUT_WIDTH +: OUT_WIDTH];
      end else begin
        wr_word[k] = data[k*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_fire) begin
      for (int unsigned k = 0; k < RATIO; k++) begin
        mem[k][wr_row] <= wr_word[k];
      end
    end
  end

  always_comb begin
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    bank_valid_d = bank_valid_q;
    bank_len_d   = bank_len_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    q_d          = q_q;
    q_valid_d    = 1'b0;
    err_d        = err_q;

    if (clear) begin
      wr_bank_d    = 1'b0;
      rd_bank_d    = 1'b0;
      bank_valid_d = '0;
      bank_len_d   = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      q_d          = '0;
      err_d        = 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_next;
        if (commit) begin
          bank_valid_d[wr_bank_q] = 1'b1;
          bank_len_d[wr_bank_q]   = wr_next;
          wr_ptr_d                = '0;
          wr_bank_d               = ~wr_bank_q;
        end
      end else if (wr) begin
        err_d = 1'b1;
      end

      if (rd_fire) begin
        q_d       = mem[rd_lane][rd_row];
        q_valid_d = 1'b1;
        rd_ptr_d  = rd_ptr_q + CW'(1);
      end else if (rd) begin
        err_d = 1'b1;
      end

      // Release overrides the read's pointer advance: the read already used the old bank.
      if (rel_fire) begin
        bank_valid_d[rd_bank_q] = 1'b0;
        rd_ptr_d                = '0;
        rd_bank_d               = ~rd_bank_q;
      end else if (rd_release) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      bank_valid_q <= '0;
      bank_len_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      q_q          <= '0;
      q_valid_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      bank_valid_q <= bank_valid_d;
      bank_len_q   <= bank_len_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      q_q          <= q_d;
      q_valid_q    <= q_valid_d;
      err_q        <= err_d;
    end
  end

endmodule
